// File: rtl/seg7_pkg.sv
// Glyph constants and helpers for the seven-segment scan driver.
// Segment vectors are active-low, ordered {a,b,c,d,e,f,g}: bit 6 is a, bit 0 is g.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  function automatic logic [SEG_W-1:0] glyph(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    case (nib)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble-to-segment encoder with BCD/hex selection and forced blanking.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             hex_mode,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  // In BCD mode the A-F codes are not valid digits, so they show nothing.
  always_comb begin
    if (blank || (!hex_mode && (nibble > 4'd9))) begin
      seg = SEG_BLANK;
    end else begin
      seg = glyph(nibble);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver: double-buffered nibble value,
// one digit per DIV-cycle slot, registered active-low anode/segment outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [SEG_W-1:0]      seg,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] pend_buf;
  logic [4*DIGITS-1:0] shadow;

  logic                slot_end;
  logic                frame_wrap;
  logic [3:0]          cur_nibble;
  logic [DIGITS-1:0]   lz_mask;
  logic                cur_blank;
  logic [SEG_W-1:0]    enc_seg;

  assign slot_end   = (div_cnt == DIV_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign cur_nibble = shadow[4*idx +: 4];

  // lz_mask[i] is set when digit i and every digit above it are zero; digit 0 stays lit.
  always_comb begin : lz_scan
    logic above_zero;
    above_zero = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      above_zero = above_zero && (shadow[4*i +: 4] == 4'd0);
      lz_mask[i] = above_zero;
    end
  end

  assign cur_blank = blank_lz && lz_mask[idx];

  seg7_encode u_encode (
    .nibble   (cur_nibble),
    .hex_mode (hex_mode),
    .blank    (cur_blank),
    .seg      (enc_seg)
  );

  // The transfer reads pend_buf before a same-edge load overwrites it, so the
  // load assignments come last and win on pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      pend_buf   <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + DIV_W'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      frame_done <= frame_wrap;
      an         <= ~(DIGITS'(1) << idx);
      seg        <= enc_seg;
      if (frame_wrap && pending) begin
        shadow  <= pend_buf;
        pending <= 1'b0;
      end
      if (load) begin
        pend_buf <= value;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4): directed scenarios
// plus randomized traffic against a cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [3:0] AN_SEQ   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG_1234 [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [15:0] value    = '0;
  logic        load     = 1'b0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic        pending;

  int checks = 0;
  int errors = 0;

  int          m_edges    = 0;
  logic [15:0] m_shadow   = '0;
  logic [15:0] m_pend_buf = '0;
  logic        m_pending  = 1'b0;
  logic [3:0]  exp_an     = 4'hF;
  logic [6:0]  exp_seg    = 7'h7F;
  logic        exp_fd     = 1'b0;
  logic        exp_pend   = 1'b0;

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .hex_mode   (hex_mode),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [15:0] shown, input int d,
                                           input logic hex, input logic lz);
    logic [3:0] nib;
    nib = 4'(shown >> (4*d));
    if (lz && d > 0 && (shown >> (4*d)) == 16'd0) return 7'h7F;
    if (!hex && nib > 4'd9) return 7'h7F;
    return GLYPH_TAB[nib];
  endfunction

  // Reference: the digit on display after edge e is ((e-1)/DIV) mod DIGITS and a
  // frame boundary falls on every FRAME-th edge after reset release.
  initial begin : model
    int d;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_edges    = 0;
        m_shadow   = '0;
        m_pend_buf = '0;
        m_pending  = 1'b0;
        exp_an     = 4'hF;
        exp_seg    = 7'h7F;
        exp_fd     = 1'b0;
        exp_pend   = 1'b0;
      end else begin
        m_edges++;
        d       = ((m_edges - 1) / DIV) % DIGITS;
        exp_an  = ~(4'b0001 << d);
        exp_seg = ref_glyph(m_shadow, d, hex_mode, blank_lz);
        exp_fd  = (m_edges % FRAME) == 0;
        if (exp_fd && m_pending) begin
          m_shadow  = m_pend_buf;
          m_pending = 1'b0;
        end
        if (load) begin
          m_pend_buf = value;
          m_pending  = 1'b1;
        end
        exp_pend = m_pending;
      end
    end
  end

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 2*FRAME + 2; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int last;
    rst = 1'b1; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {4'b1111, 7'b1111111}) begin
        errors++;
        $display("[TB] FAIL reset_hold an/seg: got %b/%b want 1111/1111111", an, seg);
      end
      checks++;
      if ({frame_done, pending} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_hold fd/pend: got %b/%b want 0/0", frame_done, pending);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({an, seg} !== {4'b1110, 7'b0000001}) begin
      errors++;
      $display("[TB] FAIL reset_first an/seg: got %b/%b want 1110/0000001", an, seg);
    end
    last = -1;
    for (int i = 0; i < 3*FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("[TB] FAIL reset_scan an/seg: got %b/%b want %b/%b", an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({frame_done, pending} !== {exp_fd, exp_pend}) begin
        errors++;
        $display("[TB] FAIL reset_scan fd/pend: got %b/%b want %b/%b", frame_done, pending, exp_fd, exp_pend);
      end
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last != FRAME) begin
            errors++;
            $display("[TB] FAIL frame_period: got %0d want %0d", i - last, FRAME);
          end
        end
        last = i;
      end
    end
  endtask

  task automatic test_load_1234();
    bit seen;
    hex_mode = 1'b0; blank_lz = 1'b0;
    wait_fd(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL load_align: got no frame_done want pulse");
    end
    pulse_load(16'h1234);
    seen = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({frame_done, pending} !== {exp_fd, exp_pend}) begin
        errors++;
        $display("[TB] FAIL load_wait fd/pend: got %b/%b want %b/%b", frame_done, pending, exp_fd, exp_pend);
      end
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL load_transfer: got no frame_done want pulse");
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {AN_SEQ[k/DIV], SEG_1234[k/DIV]}) begin
        errors++;
        $display("[TB] FAIL load_1234 slot %0d an/seg: got %b/%b want %b/%b", k, an, seg, AN_SEQ[k/DIV], SEG_1234[k/DIV]);
      end
    end
  endtask

  task automatic test_hex();
    hex_mode = 1'b0; blank_lz = 1'b0;
    pulse_load(16'h00AF);
    repeat (2*FRAME + 2) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("[TB] FAIL bcd_scan an/seg: got %b/%b want %b/%b", an, seg, exp_an, exp_seg);
      end
    end
    hex_mode = 1'b1;
    repeat (FRAME + 2) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("[TB] FAIL hex_scan an/seg: got %b/%b want %b/%b", an, seg, exp_an, exp_seg);
      end
      if (an === 4'b1110) begin
        checks++;
        if (seg !== 7'b0111000) begin
          errors++;
          $display("[TB] FAIL hex_digit0: got %b want 0111000", seg);
        end
      end
      if (an === 4'b1101) begin
        checks++;
        if (seg !== 7'b0001000) begin
          errors++;
          $display("[TB] FAIL hex_digit1: got %b want 0001000", seg);
        end
      end
    end
    hex_mode = 1'b0;
  endtask

  task automatic test_blanking();
    logic [6:0] want;
    blank_lz = 1'b1; hex_mode = 1'b0;
    pulse_load(16'h0050);
    repeat (2*FRAME + 2) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("[TB] FAIL blank_scan an/seg: got %b/%b want %b/%b", an, seg, exp_an, exp_seg);
      end
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      want = 7'b1111111;
      if (an === 4'b1101) want = 7'b0100100;
      if (an === 4'b1110) want = 7'b0000001;
      checks++;
      if (seg !== want || an === 4'b1111) begin
        errors++;
        $display("[TB] FAIL blank_0050 an/seg: got %b/%b want seg %b with anode low", an, seg, want);
      end
    end
    pulse_load(16'h0000);
    repeat (2*FRAME + 2) @(negedge clk);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      want = (an === 4'b1110) ? 7'b0000001 : 7'b1111111;
      checks++;
      if ({an, seg} !== {exp_an, want}) begin
        errors++;
        $display("[TB] FAIL blank_0000 an/seg: got %b/%b want %b/%b", an, seg, exp_an, want);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_double_load();
    bit seen;
    int ones;
    int twos;
    hex_mode = 1'b0; blank_lz = 1'b0;
    wait_fd(seen);
    pulse_load(16'h1111);
    repeat (2) @(negedge clk);
    pulse_load(16'h2222);
    ones = 0; twos = 0;
    repeat (3*FRAME) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_done, pending} !== {exp_an, exp_seg, exp_fd, exp_pend}) begin
        errors++;
        $display("[TB] FAIL double_scan an/seg/fd/pend: got %b/%b/%b/%b want %b/%b/%b/%b",
                 an, seg, frame_done, pending, exp_an, exp_seg, exp_fd, exp_pend);
      end
      if (seg === 7'b1001111) ones++;
      if (seg === 7'b0010010) twos++;
    end
    checks++;
    if (ones != 0 || twos == 0) begin
      errors++;
      $display("[TB] FAIL double_last_wins: got %0d cycles of 1 and %0d of 2 want 0 and >0", ones, twos);
    end
  endtask

  task automatic test_collision();
    bit seen;
    hex_mode = 1'b0; blank_lz = 1'b0;
    wait_fd(seen);
    pulse_load(16'h3333);
    repeat (FRAME - 2) begin
      @(negedge clk);
      checks++;
      if ({frame_done, pending} !== {exp_fd, exp_pend}) begin
        errors++;
        $display("[TB] FAIL collide_pre fd/pend: got %b/%b want %b/%b", frame_done, pending, exp_fd, exp_pend);
      end
    end
    value = 16'h4444;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    checks++;
    if ({frame_done, pending} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL collide_edge fd/pend: got %b/%b want 1/1", frame_done, pending);
    end
    for (int k = 0; k < FRAME - 1; k++) begin
      @(negedge clk);
      checks++;
      if ({seg, pending} !== {7'b0000110, 1'b1}) begin
        errors++;
        $display("[TB] FAIL collide_old seg/pend: got %b/%b want 0000110/1", seg, pending);
      end
    end
    repeat (2*FRAME) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_done, pending} !== {exp_an, exp_seg, exp_fd, exp_pend}) begin
        errors++;
        $display("[TB] FAIL collide_new an/seg/fd/pend: got %b/%b/%b/%b want %b/%b/%b/%b",
                 an, seg, frame_done, pending, exp_an, exp_seg, exp_fd, exp_pend);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    hex_mode = 1'b0; blank_lz = 1'b0;
    wait_fd(seen);
    pulse_load(16'h5678);
    repeat (8) @(negedge clk);
    checks++;
    if ({an, pending} !== {4'b1011, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rstmid_pre an/pend: got %b/%b want 1011/1", an, pending);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, frame_done, pending} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rstmid_reset an/seg/fd/pend: got %b/%b/%b/%b want 1111/1111111/0/0",
               an, seg, frame_done, pending);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({an, seg} !== {4'b1110, 7'b0000001}) begin
      errors++;
      $display("[TB] FAIL rstmid_restart an/seg: got %b/%b want 1110/0000001", an, seg);
    end
    repeat (2*FRAME) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_done, pending} !== {exp_an, exp_seg, exp_fd, exp_pend}) begin
        errors++;
        $display("[TB] FAIL rstmid_scan an/seg/fd/pend: got %b/%b/%b/%b want %b/%b/%b/%b",
                 an, seg, frame_done, pending, exp_an, exp_seg, exp_fd, exp_pend);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      value    = 16'($urandom) >> (4 * $urandom_range(0, 4));
      load     = ($urandom_range(0, 9) == 0);
      hex_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      @(negedge clk);
      checks++;
      if ({an, seg} !== {exp_an, exp_seg}) begin
        errors++;
        $display("[TB] FAIL random an/seg cycle %0d: got %b/%b want %b/%b", i, an, seg, exp_an, exp_seg);
      end
      checks++;
      if ({frame_done, pending} !== {exp_fd, exp_pend}) begin
        errors++;
        $display("[TB] FAIL random fd/pend cycle %0d: got %b/%b want %b/%b", i, frame_done, pending, exp_fd, exp_pend);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_hex();
    test_blanking();
    test_double_load();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
